// File: rtl/window_scheduler_pkg.sv
// Shared types and field widths for the convolution window scheduler.
package conv_sched_pkg;

  localparam int STRIDE_W = 3;
  localparam int FS_W     = 4;
  localparam int NF_W     = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/window_scheduler_if.sv
// Tap stream between the scheduler (master) and the MAC datapath (slave).
interface window_scheduler_if #(
  parameter int DATA_AW = 5,
  parameter int FILT_AW = 6
);
  logic               valid;
  logic               ready;
  logic [DATA_AW-1:0] data_addr;
  logic [FILT_AW-1:0] filter_addr;
  logic               win_last;
  logic               row_last;
  logic               all_last;

  modport master (
    output valid, data_addr, filter_addr, win_last, row_last, all_last,
    input  ready
  );

  modport slave (
    input  valid, data_addr, filter_addr, win_last, row_last, all_last,
    output ready
  );
endinterface

// File: rtl/window_scheduler_tap_counter.sv
// Stepping counter that returns to zero when the next step would pass its terminal value.
module tap_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] step,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W:0] sum;

  assign sum  = {1'b0, count} + {1'b0, step};
  assign wrap = (sum > {1'b0, term});

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : sum[W-1:0];
    end
  end

endmodule

// File: rtl/window_scheduler.sv
// Walks filter f, window base b and tap k over a data row, issuing one
// data/filter address pair per accepted tap.
//
// state  | meaning
// S_IDLE | waiting for start; config inputs sampled here
// S_RUN  | issuing taps, one per valid&&ready
// S_DONE | one-cycle end-of-pass pulse (also after a rejected config)
module window_scheduler
  import conv_sched_pkg::*;
#(
  parameter int DATA_AW = 5,
  parameter int FILT_AW = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [STRIDE_W-1:0] stride,
  input  logic [FS_W-1:0]     filter_size,
  input  logic [DATA_AW:0]    row_len,
  input  logic [NF_W-1:0]     num_filters,
  input  logic [DATA_AW-1:0]  data_base,
  window_scheduler_if.master  tap,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int BW = DATA_AW + 1;
  localparam int PW = NF_W + FS_W;

  state_t state, state_next;

  logic [STRIDE_W-1:0] stride_q;
  logic [FS_W-1:0]     fs_q;
  logic [BW-1:0]       row_len_q;
  logic [NF_W-1:0]     nf_q;
  logic [DATA_AW-1:0]  base_q;

  logic [FS_W-1:0] k_cnt;
  logic [BW-1:0]   b_cnt;
  logic [NF_W-1:0] f_cnt;
  logic            k_wrap, b_wrap, f_wrap;

  logic [7:0]    fan;
  logic [PW-1:0] f_base;
  logic          cfg_legal, accept, reject, hs;

  // Total filter-buffer footprint must fit the filter address space.
  assign fan       = 8'(num_filters) * 8'(filter_size);
  assign cfg_legal = (stride != '0) && (filter_size != '0) && (num_filters != '0) &&
                     (32'(filter_size) <= 32'(row_len)) &&
                     (32'(fan) <= (32'd1 << FILT_AW));

  assign accept = (state == S_IDLE) && start && cfg_legal;
  assign reject = (state == S_IDLE) && start && !cfg_legal;
  assign hs     = tap.valid && tap.ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept)      state_next = S_RUN;
        else if (reject) state_next = S_DONE;
      end
      S_RUN:   if (hs && tap.all_last) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stride_q  <= '0;
      fs_q      <= '0;
      row_len_q <= '0;
      nf_q      <= '0;
      base_q    <= '0;
    end else if (accept) begin
      stride_q  <= stride;
      fs_q      <= filter_size;
      row_len_q <= row_len;
      nf_q      <= num_filters;
      base_q    <= data_base;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if (reject) begin
      err <= 1'b1;
    end
  end

  tap_counter #(.W(FS_W)) u_k (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .en    (hs),
    .step  (FS_W'(1)),
    .term  (fs_q - FS_W'(1)),
    .count (k_cnt),
    .wrap  (k_wrap)
  );

  // Terminal for b is the last base whose window still fits in the row.
  tap_counter #(.W(BW)) u_b (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .en    (hs && k_wrap),
    .step  (BW'(stride_q)),
    .term  (row_len_q - BW'(fs_q)),
    .count (b_cnt),
    .wrap  (b_wrap)
  );

  tap_counter #(.W(NF_W)) u_f (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .en    (hs && k_wrap && b_wrap),
    .step  (NF_W'(1)),
    .term  (nf_q - NF_W'(1)),
    .count (f_cnt),
    .wrap  (f_wrap)
  );

  assign f_base = PW'(f_cnt) * PW'(fs_q);

  assign tap.valid       = (state == S_RUN);
  assign tap.data_addr   = DATA_AW'(BW'(base_q) + b_cnt + BW'(k_cnt));
  assign tap.filter_addr = FILT_AW'(f_base) + FILT_AW'(k_cnt);
  assign tap.win_last    = tap.valid && k_wrap;
  assign tap.row_last    = tap.win_last && b_wrap;
  assign tap.all_last    = tap.row_last && f_wrap;

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_window_scheduler.sv
// Scoreboard bench for window_scheduler: a list-based reference model queues
// expected taps per pass, a negedge monitor pops and compares them.
module tb_window_scheduler;
  import conv_sched_pkg::*;

  localparam int DATA_AW = 5;
  localparam int FILT_AW = 6;

  typedef struct packed {
    logic [DATA_AW-1:0] da;
    logic [FILT_AW-1:0] fa;
    logic               w;
    logic               r;
    logic               a;
  } tap_t;

  typedef struct {
    bit err;
    int taps;
  } pass_t;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic [STRIDE_W-1:0] stride = '0;
  logic [FS_W-1:0]     filter_size = '0;
  logic [DATA_AW:0]    row_len = '0;
  logic [NF_W-1:0]     num_filters = '0;
  logic [DATA_AW-1:0]  data_base = '0;
  logic                busy, done, err;

  window_scheduler_if #(.DATA_AW(DATA_AW), .FILT_AW(FILT_AW)) tap_if ();

  window_scheduler #(.DATA_AW(DATA_AW), .FILT_AW(FILT_AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stride      (stride),
    .filter_size (filter_size),
    .row_len     (row_len),
    .num_filters (num_filters),
    .data_base   (data_base),
    .tap         (tap_if),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  tap_t  exp_q[$];
  pass_t pass_q[$];
  int    checks = 0;
  int    failures = 0;
  int    done_cnt = 0;
  int    taps_in_pass = 0;
  int    ready_mode = 1;
  int    stall_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: enumerate the window bases that fit, then every tap.
  task automatic push_pass(input int st, input int fs, input int rl, input int nf,
                           input int base, input int exp_taps);
    pass_t p;
    int    bases[$];
    int    n;
    tap_t  t;
    n = 0;
    p.err = (st == 0) || (fs == 0) || (nf == 0) || (fs > rl) || (nf * fs > (1 << FILT_AW));
    if (!p.err) begin
      for (int b = 0; b + fs <= rl; b += st) bases.push_back(b);
      for (int f = 0; f < nf; f++) begin
        for (int wi = 0; wi < bases.size(); wi++) begin
          for (int k = 0; k < fs; k++) begin
            t.da = DATA_AW'((base + bases[wi] + k) % (1 << DATA_AW));
            t.fa = FILT_AW'(f * fs + k);
            t.w  = (k == fs - 1);
            t.r  = t.w && (wi == bases.size() - 1);
            t.a  = t.r && (f == nf - 1);
            exp_q.push_back(t);
            n++;
          end
        end
      end
    end
    p.taps = (exp_taps >= 0) ? exp_taps : n;
    pass_q.push_back(p);
  endtask

  task automatic scramble_inputs();
    stride      = STRIDE_W'($urandom);
    filter_size = FS_W'($urandom);
    row_len     = (DATA_AW + 1)'($urandom);
    num_filters = NF_W'($urandom);
    data_base   = DATA_AW'($urandom);
  endtask

  task automatic issue_start(input int st, input int fs, input int rl, input int nf, input int base);
    stride      = STRIDE_W'(st);
    filter_size = FS_W'(fs);
    row_len     = (DATA_AW + 1)'(rl);
    num_filters = NF_W'(nf);
    data_base   = DATA_AW'(base);
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble_inputs();
  endtask

  task automatic run_pass(input int st, input int fs, input int rl, input int nf,
                          input int base, input int exp_taps, input bit poke_start);
    int  n0;
    bit  seen;
    bit  bad;
    n0   = done_cnt;
    seen = 1'b0;
    bad  = (st == 0) || (fs == 0) || (nf == 0) || (fs > rl) || (nf * fs > (1 << FILT_AW));
    push_pass(st, fs, rl, nf, base, exp_taps);
    issue_start(st, fs, rl, nf, base);
    chk("busy_after_start", busy, !bad);
    chk("valid_after_start", tap_if.valid, !bad);
    if (!bad) chk("err_cleared", err, 0);
    if (poke_start) begin
      repeat (2) @(posedge clk);
      #1;
      issue_start(3, 2, 5, 1, 7);
    end
    for (int i = 0; i < 10000 && !seen; i++) begin
      @(posedge clk);
      if (done_cnt > n0) seen = 1'b1;
    end
    #1;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL pass_timeout actual=no_done required=done");
    end
  endtask

  // Ready generator: 1 = always ready, 2 = random, 3 = hold off on the 4th tap.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      2: tap_if.ready = ($urandom_range(0, 3) != 0);
      3: begin
        if (taps_in_pass == 3 && stall_left > 0) begin
          tap_if.ready = 1'b0;
          stall_left--;
        end else begin
          tap_if.ready = 1'b1;
        end
      end
      default: tap_if.ready = 1'b1;
    endcase
  end

  tap_t  cur, prev_snap;
  bit    prev_stall = 1'b0;
  bit    prev_all = 1'b0;
  pass_t pp;

  always @(negedge clk) begin
    if (!rst) begin
      taps_in_pass = 0;
      prev_stall   = 1'b0;
      prev_all     = 1'b0;
    end else begin
      cur.da = tap_if.data_addr;
      cur.fa = tap_if.filter_addr;
      cur.w  = tap_if.win_last;
      cur.r  = tap_if.row_last;
      cur.a  = tap_if.all_last;
      if (prev_stall && tap_if.valid) chk("stall_hold", 32'(cur), 32'(prev_snap));
      if (!tap_if.valid) chk("flags_idle", {29'd0, cur.w, cur.r, cur.a}, 0);
      if (tap_if.valid && tap_if.ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_tap actual=%0h required=none", cur);
        end else begin
          chk("tap", 32'(cur), 32'(exp_q.pop_front()));
        end
        taps_in_pass++;
      end
      if (done) begin
        if (pass_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          pp = pass_q.pop_front();
          chk("err_at_done", err, pp.err);
          chk("tap_count", taps_in_pass, pp.taps);
          chk("done_after_last", prev_all, !pp.err);
          chk("queue_drained", exp_q.size(), 0);
        end
        taps_in_pass = 0;
        done_cnt++;
      end
      prev_all   = tap_if.valid && tap_if.ready && tap_if.all_last;
      prev_stall = tap_if.valid && !tap_if.ready;
      prev_snap  = cur;
    end
  end

  initial begin
    int  st, fs, rl, nf, bs;
    bit  reached;
    tap_if.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_valid", tap_if.valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_data_addr", tap_if.data_addr, 0);
    chk("reset_filter_addr", tap_if.filter_addr, 0);

    ready_mode = 1;
    run_pass(1, 3, 8, 2, 0, 36, 0);
    run_pass(2, 3, 8, 1, 0, 9, 0);
    run_pass(1, 4, 4, 1, 30, 4, 0);
    ready_mode = 3;
    stall_left = 3;
    run_pass(1, 3, 8, 2, 0, 36, 0);
    ready_mode = 1;
    run_pass(1, 3, 8, 1, 0, 18, 1);

    run_pass(1, 9, 8, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("err_sticky", err, 1);
    chk("illegal_no_valid", tap_if.valid, 0);
    run_pass(0, 3, 8, 1, 0, 0, 0);
    run_pass(1, 13, 16, 5, 0, 0, 0);
    run_pass(7, 9, 9, 7, 5, 63, 0);

    // Reset in the middle of a pass, then a clean restart.
    push_pass(1, 3, 8, 2, 0, 36);
    issue_start(1, 3, 8, 2, 0);
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      if (taps_in_pass >= 5) reached = 1'b1;
      else @(posedge clk);
    end
    #1;
    chk("reached_tap5", reached, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    pass_q.delete();
    chk("midreset_valid", tap_if.valid, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_data_addr", tap_if.data_addr, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_pass(1, 3, 8, 2, 0, 36, 0);

    ready_mode = 2;
    for (int i = 0; i < 20; i++) begin
      st = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 7));
      fs = $urandom_range(1, 15);
      rl = $urandom_range(1, 32);
      nf = $urandom_range(1, 7);
      bs = $urandom_range(0, 31);
      run_pass(st, fs, rl, nf, bs, -1, 0);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_scheduler.md
WINDOW_SCHEDULER -- requirements
Module: window_scheduler

Interface
REQ-001 Parameters SHALL be: DATA_AW, default 5, data-buffer address width; FILT_AW, default 6, filter-buffer address width.
REQ-002 clk  in  1  single clock, rising edge; all state changes on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-low (rst=0 resets on the next posedge clk).
REQ-004 start  in  1  begin a pass; sampled only in IDLE.
REQ-005 stride  in  3  window step, legal range 1..7.
REQ-006 filter_size  in  4  taps per window, legal range 1..15.
REQ-007 row_len  in  DATA_AW+1  valid data words in the row, legal range 1..2^DATA_AW.
REQ-008 num_filters  in  3  filters to apply, legal range 1..7.
REQ-009 data_base  in  DATA_AW  data-buffer address of row element 0.
REQ-010 ready  in  1  datapath accepts the current tap.
REQ-011 valid  out  1  data_addr and filter_addr carry a tap.
REQ-012 data_addr  out  DATA_AW  data-buffer read address.
REQ-013 filter_addr  out  FILT_AW  filter-buffer read address.
REQ-014 win_last  out  1  current tap is the last tap of a window.
REQ-015 row_last  out  1  current tap is the last tap of the last window in the row for this filter.
REQ-016 all_last  out  1  current tap is the final tap of the pass.
REQ-017 busy  out  1  pass in progress.
REQ-018 done  out  1  one-cycle pulse at end of pass.
REQ-019 err  out  1  configuration rejected; sticky until next accepted start or reset.

Function
REQ-020 States SHALL be: IDLE, RUN, DONE.
- IDLE->RUN: start=1 with legal config.
- IDLE->DONE: start=1 with illegal config; err=1.
- RUN->DONE: handshake on the all_last tap.
- DONE->IDLE: always, after one cycle.
REQ-021 On the accepted start edge, the block SHALL latch stride, filter_size, row_len, num_filters and data_base; later input changes SHALL have no effect until the next pass.
REQ-022 A config SHALL be illegal if any holds:
- stride=0
- filter_size=0
- num_filters=0
- filter_size>row_len
- num_filters*filter_size>2^FILT_AW
REQ-023 Counters SHALL be: filter index f, window base b, tap index k, all zero at start.
- valid=1 in the cycle after an accepted start; valid=1 throughout RUN; valid=0 otherwise.
REQ-024 data_addr SHALL equal (data_base+b+k) mod 2^DATA_AW; wrap-around is legal.
REQ-025 filter_addr SHALL equal f*filter_size+k.
REQ-026 Counters SHALL advance only on valid&&ready.
- Advance k.
- At k=filter_size-1: k=0, b+=stride.
- If b+stride+filter_size>row_len: b=0, f+=1.
REQ-027 While valid&&!ready, all outputs SHALL hold stable.
REQ-028 Tap flags SHALL be combinational from state and counters, asserted with valid, and not qualified by ready.
- win_last=(k=filter_size-1).
- row_last=win_last && (b+stride+filter_size>row_len).
- all_last=row_last && (f=num_filters-1).
REQ-029 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only.
REQ-030 start while busy or in DONE SHALL be ignored.
REQ-031 filter_size=row_len SHALL yield exactly one window per filter.

Reset
REQ-032 On rst=0, at the next edge, from any state including mid-RUN:
- state=IDLE
- f, b, k and all latched config =0
- valid=busy=done=err=0
- data_addr=filter_addr=0
REQ-033 rst SHALL have priority over start and ready in the same cycle.

Structure
REQ-034 Package conv_sched_pkg SHALL hold: the state enum; width constants for stride (3), filter_size (4) and num_filters (3).
REQ-035 One sub-module tap_counter SHALL be used: clear, enable, programmable terminal value, wrap output. It is instanced for k, b (step=stride) and f.
REQ-036 RTL SHALL target 150-300 lines with registered state and counters only.

Verification
REQ-037 row_len=8, fs=3, stride=1, nf=2, base=0, ready=1:
- 36 taps; win_last every 3rd tap.
- row_last at taps 18 and 36; all_last at tap 36.
- done one cycle after tap 36.
- Filter 1 filter_addr values 3..5.
REQ-038 row_len=8, fs=3, stride=2, nf=1, ready=1:
- Window bases 0, 2, 4; 9 taps.
- data_addr sequence 0,1,2,2,3,4,4,5,6.
REQ-039 base=30, row_len=4, fs=4, stride=1, nf=1 -> data_addr sequence 30,31,0,1.
REQ-040 Backpressure: ready=0 for 3 cycles at tap 4 -> addresses and flags stable; total taps unchanged.
REQ-041 Illegal config: fs=9, row_len=8 -> err=1, done pulse, valid never asserted.
REQ-042 Reset mid-pass: rst=0 during RUN at tap 5 -> next cycle valid=0, busy=0, state IDLE. A new start then restarts from tap 0.
